// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: data width, 50 MHz baud divisors and rx frame states.
// The divisor constants are the same values the transmitter uses so both ends stay matched.
package uart_rx_pkg;

    localparam int VLD_DATA_WIDTH = 8;
    localparam int DIV_W          = 17;

    localparam logic [DIV_W-1:0] DIV_600   = 17'd83333;
    localparam logic [DIV_W-1:0] DIV_1200  = 17'd41667;
    localparam logic [DIV_W-1:0] DIV_2400  = 17'd20833;
    localparam logic [DIV_W-1:0] DIV_4800  = 17'd10417;
    localparam logic [DIV_W-1:0] DIV_9600  = 17'd5208;
    localparam logic [DIV_W-1:0] DIV_19200 = 17'd2604;
    localparam logic [DIV_W-1:0] DIV_38400 = 17'd1302;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Selector 7 is unused by the transmitter table and falls back to the slowest rate.
    function automatic logic [DIV_W-1:0] bps_div(input logic [2:0] sel);
        logic [DIV_W-1:0] div;
        case (sel)
            3'd0:    div = DIV_600;
            3'd1:    div = DIV_1200;
            3'd2:    div = DIV_2400;
            3'd3:    div = DIV_4800;
            3'd4:    div = DIV_9600;
            3'd5:    div = DIV_19200;
            3'd6:    div = DIV_38400;
            default: div = DIV_600;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-data bus from the UART receiver to its consumer (FIFO, register file).
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dout;
    logic              vld;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output dout,
        output vld,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        input dout,
        input vld,
        input parity_err,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector.
module uart_rx_sync (
    input  logic CLK,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic rx_m;
    logic rx_d;

    // Clearing to 0 means a line held low at reset release never looks like a falling edge.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
            rx_d <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_W data bits LSB first, parity, stop; single mid-bit sample per bit.
// Each completed frame is presented with a one-cycle vld strobe and held parity/framing flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = VLD_DATA_WIDTH
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       rx,
    input  logic [2:0] bps_sel,
    input  logic       check_sel,
    uart_rx_if.master  rx_bus
);
    localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);

    rx_state_t state, state_nx;

    logic             rx_s;
    logic             fall;
    logic [DIV_W-1:0] div_sel;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] half_q;
    logic             check_q;
    logic [DIV_W-1:0] bps_cnt;
    logic [3:0]       bit_cnt;
    logic [DATA_W-1:0] shift;
    logic             par_bit;

    logic             half_tick;
    logic             bit_tick;
    logic             accept;
    logic             cnt_clr;
    logic             bit_clr;
    logic             shift_en;
    logic             par_en;
    logic             stop_en;

    logic [DATA_W-1:0] dout_q;
    logic             vld_q;
    logic             parity_err_q;
    logic             frame_err_q;

    uart_rx_sync u_sync (
        .CLK  (CLK),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign div_sel   = bps_div(bps_sel);
    assign half_tick = (bps_cnt == half_q - DIV_W'(1));
    assign bit_tick  = (bps_cnt == div_q - DIV_W'(1));

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        cnt_clr  = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    accept   = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (half_tick) begin
                    cnt_clr  = 1'b1;
                    bit_clr  = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nx = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    par_en   = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (bit_tick) begin
                    stop_en  = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Rate and parity mode are frozen per frame so mid-frame changes only affect the next one.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            half_q  <= '0;
            check_q <= 1'b0;
        end else if (accept) begin
            div_q   <= div_sel;
            half_q  <= div_sel >> 1;
            check_q <= check_sel;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bps_cnt <= '0;
        end else if (cnt_clr) begin
            bps_cnt <= '0;
        end else if (state != IDLE) begin
            bps_cnt <= bps_cnt + DIV_W'(1);
        end
    end

    // Data arrives LSB first, so shifting in from the top leaves bit 0 at the LSB after DATA_W bits.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (shift_en) begin
                shift <= {rx_s, shift[DATA_W-1:1]};
            end
            if (par_en) begin
                par_bit <= rx_s;
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            vld_q        <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            vld_q <= stop_en;
            if (stop_en) begin
                dout_q       <= shift;
                parity_err_q <= par_bit ^ (^shift) ^ check_q;
                frame_err_q  <= ~rx_s;
            end
        end
    end

    assign rx_bus.dout       = dout_q;
    assign rx_bus.vld        = vld_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.busy       = (state != IDLE);

endmodule
